// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side circular byte FIFO between the UART receive
//            controller and the register block. It captures bytes on the
//            receiver's done pulse, presents the head entry first-word
//            fall-through over a valid/ready handshake, and flags lost pushes
//            with a sticky overflow bit.
// Options  : UART_RX_FIFO_DROP_ERR_EN - when defined, bytes flagged with
//            in_err are discarded and out_err is tied low. When undefined,
//            errored bytes are stored and tagged.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                       clk_16mhz,
  input  logic                       rstn,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_err,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       overflow_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Errored bytes never reach storage, so entries only need the data field.
  localparam int ENTRY_W = DATA_WIDTH;
`else
  // Each entry carries the receiver error tag above the data byte.
  localparam int ENTRY_W = DATA_WIDTH + 1;
`endif

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DEPTH   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_AF      = CNT_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic               w_push_req;
  logic               w_push;
  logic               w_pop;
  logic               w_lost;
  logic               w_full;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  // Status flags are pure decodes of the registered occupancy.
  always_comb begin
    w_full      = (r_count == c_DEPTH);
    out_valid   = (r_count != '0);
    full        = w_full;
    almost_full = (r_count >= c_AF);
    count       = r_count;
    overflow    = r_overflow;
  end

  // Push/pop qualification; flush overrides any traffic in the same cycle.
  always_comb begin
`ifdef UART_RX_FIFO_DROP_ERR_EN
    w_push_req = in_valid && !in_err;
    w_wr_entry = in_data;
`else
    w_push_req = in_valid;
    w_wr_entry = {in_err, in_data};
`endif
    w_pop  = out_valid && out_ready && !flush;
    // A pop in the same cycle frees the slot the push needs, even when full.
    w_push = w_push_req && (!w_full || w_pop) && !flush;
    w_lost = w_push_req && w_full && !w_pop && !flush;
  end

  // Head entry is read combinationally at the read pointer (fall-through).
  always_comb begin
    w_head = r_mem[r_rptr];
`ifdef UART_RX_FIFO_DROP_ERR_EN
    out_data = w_head;
    out_err  = 1'b0;
`else
    out_data = w_head[DATA_WIDTH-1:0];
    out_err  = w_head[DATA_WIDTH];
`endif
  end

  // Storage array write; contents are intentionally not reset.
  always_ff @(posedge clk_16mhz) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wr_entry;
    end
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_16mhz) begin
    if (!rstn || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Sticky overflow; a lost push in the same cycle beats the clear.
  always_ff @(posedge clk_16mhz) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (w_lost) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo using directed sequences
//            and random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic          clk_16mhz = 1'b0;
  logic          rstn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_err;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          overflow_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {err, data}, plus the sticky overflow bit.
  logic [DW:0] mq[$];
  bit          m_ovf;

  always #31 clk_16mhz = ~clk_16mhz;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF)
  ) dut (
    .clk_16mhz    (clk_16mhz),
    .rstn         (rstn),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_err       (in_err),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .flush        (flush),
    .count        (count),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output against the model.
  task automatic compare_all(input string tag);
    logic [DW:0] head;
    check({tag, ".count"},  32'(count),       32'(mq.size()));
    check({tag, ".valid"},  32'(out_valid),   32'(mq.size() > 0));
    check({tag, ".full"},   32'(full),        32'(mq.size() == DEPTH));
    check({tag, ".afull"},  32'(almost_full), 32'(mq.size() >= AF));
    check({tag, ".ovf"},    32'(overflow),    32'(m_ovf));
    if (mq.size() > 0) begin
      head = mq[0];
      check({tag, ".data"}, 32'(out_data), 32'(head[DW-1:0]));
      check({tag, ".err"},  32'(out_err),  32'(head[DW]));
    end
  endtask

  // Apply one cycle of inputs, advance the model with the same inputs, check.
  task automatic cycle(input string tag, input bit fl, input bit v, input bit e,
                       input logic [DW-1:0] d, input bit rdy, input bit clr);
    bit pop;
    bit lost;
    flush = fl; in_valid = v; in_err = e; in_data = d;
    out_ready = rdy; overflow_clr = clr;
    @(posedge clk_16mhz);
    lost = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      pop = (mq.size() > 0) && rdy;
      if (pop) void'(mq.pop_front());
      if (v && !(DROP_ERR && e)) begin
        if (mq.size() < DEPTH) mq.push_back({(DROP_ERR ? 1'b0 : e), d});
        else lost = 1'b1;
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    flush = 0; in_valid = 0; in_err = 0; in_data = '0; out_ready = 0; overflow_clr = 0;
    repeat (2) @(posedge clk_16mhz);
    #1;
    rstn = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    compare_all("reset");
  endtask

  task automatic fill_seq(input string tag);
    for (int i = 0; i < DEPTH; i++) cycle(tag, 0, 1, 0, DW'(i), 0, 0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (mq.size() > 0 && guard < 4 * DEPTH) begin
      cycle(tag, 0, 0, 0, '0, 1, 0);
      guard++;
    end
    check({tag, ".drained"}, 32'(count), 32'(0));
  endtask

  initial begin
    do_reset();

    // Single byte through the FIFO.
    cycle("push_a5", 0, 1, 0, 8'hA5, 0, 0);
    check("a5_value", 32'(out_data), 32'h0A5);
    cycle("pop_a5", 0, 0, 0, '0, 1, 0);

    // Fill to full, lose one byte, drain in order.
    fill_seq("fill");
    check("full_flag", 32'(full), 32'(1));
    cycle("lost_10", 0, 1, 0, 8'h10, 0, 0);
    check("ovf_set", 32'(overflow), 32'(1));
    drain("drain1");

    // Full with simultaneous pop: push accepted, no overflow.
    cycle("clr", 0, 0, 0, '0, 0, 1);
    fill_seq("fill2");
    cycle("push_pop_full", 0, 1, 0, 8'h55, 1, 0);
    check("pp_count", 32'(count), 32'(DEPTH));
    check("pp_ovf", 32'(overflow), 32'(0));
    drain("drain2");

    // Overflow clear racing a lost push.
    fill_seq("fill3");
    cycle("lost_a", 0, 1, 0, 8'hEE, 0, 0);
    cycle("lost_clr", 0, 1, 0, 8'hEF, 0, 1);
    check("ovf_wins", 32'(overflow), 32'(1));
    cycle("clr_only", 0, 0, 0, '0, 0, 1);
    check("ovf_cleared", 32'(overflow), 32'(0));
    drain("drain3");

    // Errored byte.
    cycle("err_3c", 0, 1, 1, 8'h3C, 0, 0);
    if (DROP_ERR) check("err_dropped", 32'(count), 32'(0));
    else          check("err_tag", 32'(out_err), 32'(1));
    drain("drain4");

    // Flush with a simultaneous push, then wrap the pointers.
    for (int i = 0; i < 9; i++) cycle("fill9", 0, 1, 0, DW'(8'h80 + i), 0, 0);
    cycle("flush", 1, 1, 0, 8'h77, 0, 0);
    check("flush_count", 32'(count), 32'(0));
    for (int i = 0; i < 20; i++) begin
      cycle("wrap_push", 0, 1, 0, DW'(8'hC0 + i), 0, 0);
      cycle("wrap_pop", 0, 0, 0, '0, 1, 0);
    end

    // Random traffic in phases of different read pressure.
    for (int ph = 0; ph < 8; ph++) begin
      int rdy_pct;
      rdy_pct = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 90 : 50;
      for (int i = 0; i < 300; i++) begin
        cycle("rand",
              ($urandom_range(0, 199) == 0),
              ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 99) < 20),
              DW'($urandom),
              ($urandom_range(0, 99) < rdy_pct),
              ($urandom_range(0, 49) == 0));
      end
    end

    // Reset mid-stream loses contents.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 0, 1, 0, DW'(i + 1), 0, 0);
    do_reset();
    cycle("post_rst", 0, 1, 0, 8'h42, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receive controller. It captures each byte qualified by the receiver's one-cycle done pulse and holds it in a circular FIFO until the core-side reader consumes it through a valid/ready handshake. The receiver cannot be stalled, so the FIFO also reports overflow and tags or drops bytes the receiver flagged as corrupt. It bridges the bit-level receiver and the memory-mapped UART register block.

## Interface
- DATA_WIDTH, 8, byte width; matches receiver output width
- DEPTH, 16, entry count; power of two, >= 2
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; 1 <= AF_LEVEL <= DEPTH
- clk_16mhz  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- in_data  in  DATA_WIDTH  received byte from the receiver
- in_valid  in  1  one-cycle push strobe, driven by the receiver's done pulse
- in_err  in  1  receiver error for this byte, sampled only with in_valid
- out_data  out  DATA_WIDTH  head entry data (first-word fall-through)
- out_err  out  1  head entry error tag
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  reader accepts head when out_valid && out_ready
- flush  in  1  discard all contents
- count  out  $clog2(DEPTH)+1  current occupancy
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_LEVEL
- overflow  out  1  sticky: a push was lost
- overflow_clr  in  1  clears overflow

## Operation
- Storage: DEPTH x (DATA_WIDTH+1) array {err, data}; write pointer wptr, read pointer rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy kept in count register.
- Push: in_valid && (!full || pop) -> write {in_err, in_data} at wptr, wptr+1.
- Pop: out_valid && out_ready -> rptr+1.
- count: +1 push only, -1 pop only, unchanged on push+pop.
- Full with simultaneous pop: push accepted (no overflow).
- Full without pop: byte discarded, pointers unchanged, overflow <= 1.
- overflow_clr clears overflow; a new overflow in the same cycle wins (stays 1).
- flush: wptr, rptr, count <= 0; any push/pop same cycle ignored; overflow unaffected.
- Empty with out_ready: no effect; out_data/out_err don't-care while out_valid=0.
- No internal state machine beyond pointer/count registers; all flags derived from count.

## Timing
- Reset (rstn=0 at clock edge): wptr=rptr=0, count=0, out_valid=0, full=0, almost_full=0, overflow=0. Array contents not reset.
- Push latency: in_valid at edge N -> entry visible (out_valid=1, out_data valid) after edge N+1 when previously empty.
- out_data/out_err combinational from array at rptr; stable while out_valid && !out_ready.
- Pop at edge N -> next entry presented after edge N, same cycle as count update.
- count, full, almost_full, overflow registered; update one cycle after the causing edge inputs.
- Back-to-back pushes every cycle supported (receiver produces at most one per ~1390 cycles at 115200 baud).
- Reset or flush mid-stream: all stored bytes lost; next push starts at index 0.

## Configuration
- UART_RX_FIFO_DROP_ERR_EN defined: bytes with in_err=1 are not stored (pointers/count unchanged, no overflow); out_err tied 0.
- Undefined: errored bytes stored like any other; out_err presents the tag with the head entry.

## Test plan
- Reset, push 0xA5 (in_err=0) -> out_valid=1 one cycle later, out_data=0xA5, count=1; pop -> count=0, out_valid=0.
- Push 16 bytes 0x00..0x0F with out_ready=0 -> almost_full at count 12, full at 16; push 0x10 -> dropped, overflow=1; pop all -> 0x00..0x0F in order.
- Full FIFO, push 0x55 with out_ready=1 same cycle -> count stays 16, overflow stays 0, 0x55 read last.
- overflow=1, assert overflow_clr together with a lost push -> overflow remains 1; overflow_clr alone -> 0.
- Push 0x3C with in_err=1 -> macro defined: count=0, out_valid=0; undefined: out_data=0x3C, out_err=1.
- Fill 9 bytes, pulse flush with simultaneous push 0x77 -> count=0, out_valid=0; subsequent 20 push/pop pairs verify pointer wrap with correct ordering.
